// File: rtl/mss_fabric_reset_sequencer.sv
// ---------------------------------------------------------------------------
// mss_fabric_reset_sequencer
//
// Fabric-side consumer of the MSS reset / CPU PLL lock signals. Waits until
// device init, MSS reset release and CPU PLL lock have all been stable for
// STABLE_CYCLES, then releases the fabric reset domains one by one, STAGE_GAP
// cycles apart. Loss of PLL lock after sequencing has started is latched as a
// FAULT until the MSS reasserts its reset. A status LED shows the phase:
// off while idle, slow blink while sequencing, fast blink on fault, on in RUN.
//
// Ports
//   clk_i               fabric clock, rising edge
//   rst_i               asynchronous active-high reset
//   device_init_done_i  init monitor done (asynchronous to clk_i)
//   mss_reset_n_m2f_i   MSS reset to fabric, active low (asynchronous)
//   pll_cpu_lock_m2f_i  MSS CPU PLL lock (asynchronous)
//   fabric_reset_n_o    staged fabric resets, active low, bit 0 first
//   ready_o             all stages released
//   fault_o             PLL lock lost after sequencing started (sticky)
//   led_o               status indicator
// ---------------------------------------------------------------------------
module mss_fabric_reset_sequencer #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned STAGES        = 3,
    parameter int unsigned STAGE_GAP     = 64,
    parameter int unsigned BLINK_DIV     = 25000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              device_init_done_i,
    input  logic              mss_reset_n_m2f_i,
    input  logic              pll_cpu_lock_m2f_i,
    output logic [STAGES-1:0] fabric_reset_n_o,
    output logic              ready_o,
    output logic              fault_o,
    output logic              led_o
);

    localparam int unsigned STAB_W  = $clog2(STABLE_CYCLES);
    localparam int unsigned GAP_W   = $clog2(STAGE_GAP) + 1;
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    localparam logic [STAB_W-1:0]  STAB_LAST       = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST        = GAP_W'(STAGE_GAP - 1);
    localparam logic [BLINK_W-1:0] BLINK_SLOW_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_FAST_LAST = BLINK_W'((BLINK_DIV / 4) - 1);
    localparam logic [STAGES-1:0]  STAGE_FIRST     = STAGES'(1);
    localparam logic [STAGES-1:0]  STAGE_ALL       = {STAGES{1'b1}};
    localparam logic [STAGES-1:0]  STAGE_NONE      = {STAGES{1'b0}};

    typedef enum logic [2:0] {
        S_WAIT_INIT   = 3'd0,
        S_WAIT_STABLE = 3'd1,
        S_RELEASE     = 3'd2,
        S_RUN         = 3'd3,
        S_FAULT       = 3'd4
    } state_t;

    // Synchronizer stages, packed as {init, rstn, lock}
    logic [2:0]         meta_q;
    logic [2:0]         sync_q;

    state_t             state_q,  state_d;
    logic [STAB_W-1:0]  stab_q,   stab_d;
    logic [GAP_W-1:0]   gap_q,    gap_d;
    logic [BLINK_W-1:0] blink_q,  blink_d;
    logic [STAGES-1:0]  frn_q,    frn_d;
    logic               ready_q,  ready_d;
    logic               fault_q,  fault_d;
    logic               led_q,    led_d;

    logic               init_s;
    logic               rstn_s;
    logic               lock_s;
    logic               qual_s;
    logic [STAGES-1:0]  frn_next_stage_s;

    assign init_s = sync_q[2];
    assign rstn_s = sync_q[1];
    assign lock_s = sync_q[0];
    assign qual_s = init_s & rstn_s & lock_s;

    // Release pattern with one more stage set; bits fill from bit 0 upwards
    assign frn_next_stage_s = (frn_q << 1) | STAGE_FIRST;

    assign fabric_reset_n_o = frn_q;
    assign ready_o          = ready_q;
    assign fault_o          = fault_q;
    assign led_o            = led_q;

    // Two-flop synchronizers for the three asynchronous qualifiers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 3'b000;
            sync_q <= 3'b000;
        end else begin
            meta_q <= {device_init_done_i, mss_reset_n_m2f_i, pll_cpu_lock_m2f_i};
            sync_q <= meta_q;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_WAIT_INIT;
            stab_q  <= {STAB_W{1'b0}};
            gap_q   <= {GAP_W{1'b0}};
            blink_q <= {BLINK_W{1'b0}};
            frn_q   <= STAGE_NONE;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            gap_q   <= gap_d;
            blink_q <= blink_d;
            frn_q   <= frn_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            led_q   <= led_d;
        end
    end

    // Sequencer next-state, counters and reset/ready/fault outputs
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        gap_d   = gap_q;
        frn_d   = frn_q;
        ready_d = ready_q;
        fault_d = fault_q;

        case (state_q)
            S_WAIT_INIT: begin
                frn_d   = STAGE_NONE;
                ready_d = 1'b0;
                fault_d = 1'b0;
                stab_d  = {STAB_W{1'b0}};
                if (qual_s) begin
                    state_d = S_WAIT_STABLE;
                end else begin
                    state_d = S_WAIT_INIT;
                end
            end

            S_WAIT_STABLE: begin
                if (!qual_s) begin
                    state_d = S_WAIT_INIT;
                    stab_d  = {STAB_W{1'b0}};
                    frn_d   = STAGE_NONE;
                    ready_d = 1'b0;
                end else if (stab_q == STAB_LAST) begin
                    gap_d = {GAP_W{1'b0}};
                    // A single-stage build has nothing left to stage: go straight to RUN
                    if (STAGES == 1) begin
                        state_d = S_RUN;
                        frn_d   = STAGE_ALL;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                        frn_d   = STAGE_FIRST;
                        ready_d = 1'b0;
                    end
                end else if (stab_q != {STAB_W{1'b1}}) begin
                    stab_d = stab_q + STAB_W'(1);
                end else begin
                    stab_d = stab_q;
                end
            end

            S_RELEASE: begin
                if (!rstn_s || !init_s) begin
                    state_d = S_WAIT_INIT;
                    frn_d   = STAGE_NONE;
                    ready_d = 1'b0;
                end else if (!lock_s) begin
                    state_d = S_FAULT;
                    frn_d   = STAGE_NONE;
                    ready_d = 1'b0;
                    fault_d = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    gap_d = {GAP_W{1'b0}};
                    frn_d = frn_next_stage_s;
                    // The edge that releases the last stage also declares READY
                    if (frn_next_stage_s[STAGES-1]) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else if (gap_q != {GAP_W{1'b1}}) begin
                    gap_d = gap_q + GAP_W'(1);
                end else begin
                    gap_d = gap_q;
                end
            end

            S_RUN: begin
                frn_d   = STAGE_ALL;
                ready_d = 1'b1;
                // MSS reset / init loss outranks lock loss on the same cycle
                if (!rstn_s || !init_s) begin
                    state_d = S_WAIT_INIT;
                    frn_d   = STAGE_NONE;
                    ready_d = 1'b0;
                end else if (!lock_s) begin
                    state_d = S_FAULT;
                    frn_d   = STAGE_NONE;
                    ready_d = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_FAULT: begin
                frn_d   = STAGE_NONE;
                ready_d = 1'b0;
                // Sticky even if lock comes back; only an MSS reset clears it
                if (!rstn_s) begin
                    state_d = S_WAIT_INIT;
                    fault_d = 1'b0;
                end else begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end
            end

            default: begin
                state_d = S_WAIT_INIT;
                stab_d  = {STAB_W{1'b0}};
                gap_d   = {GAP_W{1'b0}};
                frn_d   = STAGE_NONE;
                ready_d = 1'b0;
                fault_d = 1'b0;
            end
        endcase
    end

    // Status LED: every state change restarts the pattern from LED off
    always_comb begin
        blink_d = blink_q;
        led_d   = led_q;

        if (state_d != state_q) begin
            blink_d = {BLINK_W{1'b0}};
            led_d   = (state_d == S_RUN);
        end else begin
            case (state_q)
                S_WAIT_STABLE, S_RELEASE: begin
                    if (blink_q == BLINK_SLOW_LAST) begin
                        blink_d = {BLINK_W{1'b0}};
                        led_d   = ~led_q;
                    end else begin
                        blink_d = blink_q + BLINK_W'(1);
                    end
                end
                S_FAULT: begin
                    if (blink_q == BLINK_FAST_LAST) begin
                        blink_d = {BLINK_W{1'b0}};
                        led_d   = ~led_q;
                    end else begin
                        blink_d = blink_q + BLINK_W'(1);
                    end
                end
                S_RUN: begin
                    blink_d = {BLINK_W{1'b0}};
                    led_d   = 1'b1;
                end
                default: begin
                    blink_d = {BLINK_W{1'b0}};
                    led_d   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mss_fabric_reset_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for mss_fabric_reset_sequencer (STABLE_CYCLES=16, STAGES=3,
// STAGE_GAP=4, BLINK_DIV=8). The reference model tracks only a phase and the
// number of edges spent in it; release count and LED level are derived from
// that elapsed count arithmetically.
// ---------------------------------------------------------------------------
module tb_mss_fabric_reset_sequencer;

    localparam int SC = 16;
    localparam int ST = 3;
    localparam int SG = 4;
    localparam int BD = 8;

    localparam int M_IDLE   = 0;
    localparam int M_STABLE = 1;
    localparam int M_REL    = 2;
    localparam int M_RUN    = 3;
    localparam int M_FAULT  = 4;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          rst;
    logic          init_in;
    logic          rstn_in;
    logic          lock_in;
    logic [ST-1:0] fab;
    logic          rdy;
    logic          flt;
    logic          led;
    logic [ST+2:0] dut_vec;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            mode;
    int            elapsed;
    logic [2:0]    p1;
    logic [2:0]    p2;
    logic [ST-1:0] exp_fab;
    logic          exp_rdy;
    logic          exp_flt;
    logic          exp_led;
    logic [ST+2:0] exp_vec;

    assign dut_vec = {fab, rdy, flt, led};

    always #5 if (clk_en) clk = ~clk;

    mss_fabric_reset_sequencer #(
        .STABLE_CYCLES(SC),
        .STAGES(ST),
        .STAGE_GAP(SG),
        .BLINK_DIV(BD)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .device_init_done_i(init_in),
        .mss_reset_n_m2f_i(rstn_in),
        .pll_cpu_lock_m2f_i(lock_in),
        .fabric_reset_n_o(fab),
        .ready_o(rdy),
        .fault_o(flt),
        .led_o(led)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mode    = M_IDLE;
        elapsed = 0;
        p1      = 3'b000;
        p2      = 3'b000;
        exp_fab = '0;
        exp_rdy = 1'b0;
        exp_flt = 1'b0;
        exp_led = 1'b0;
        exp_vec = '0;
    endtask

    // One clock edge of the reference model; cur = {init, rstn, lock} at this edge
    task automatic model_edge(input logic [2:0] cur);
        logic [2:0] seen;
        int nmode;
        int rel;
        seen = p2;  // inputs become visible two edges after they are sampled
        p2   = p1;
        p1   = cur;
        nmode = mode;
        case (mode)
            M_IDLE:   if (&seen) nmode = M_STABLE;
            M_STABLE: begin
                if (!(&seen)) nmode = M_IDLE;
                else if (elapsed == SC - 1) nmode = (ST == 1) ? M_RUN : M_REL;
            end
            M_REL: begin
                if (!seen[1] || !seen[2]) nmode = M_IDLE;
                else if (!seen[0]) nmode = M_FAULT;
                else if (1 + (elapsed + 1) / SG >= ST) nmode = M_RUN;
            end
            M_RUN: begin
                if (!seen[1] || !seen[2]) nmode = M_IDLE;
                else if (!seen[0]) nmode = M_FAULT;
            end
            M_FAULT:  if (!seen[1]) nmode = M_IDLE;
            default:  nmode = M_IDLE;
        endcase
        if (nmode != mode) elapsed = 0;
        else elapsed = elapsed + 1;
        mode = nmode;

        exp_fab = '0;
        exp_rdy = 1'b0;
        exp_flt = 1'b0;
        exp_led = 1'b0;
        case (mode)
            M_STABLE: exp_led = ((elapsed / BD) % 2) == 1;
            M_REL: begin
                rel     = 1 + elapsed / SG;
                exp_fab = ST'((1 << rel) - 1);
                exp_led = ((elapsed / BD) % 2) == 1;
            end
            M_RUN: begin
                exp_fab = ST'((1 << ST) - 1);
                exp_rdy = 1'b1;
                exp_led = 1'b1;
            end
            M_FAULT: begin
                exp_flt = 1'b1;
                exp_led = ((elapsed / (BD / 4)) % 2) == 1;
            end
            default: ;
        endcase
        exp_vec = {exp_fab, exp_rdy, exp_flt, exp_led};
    endtask

    // Drive inputs, advance one edge, update the model, settle 1 time unit
    task automatic tick(input logic i, input logic r, input logic l);
        init_in = i;
        rstn_in = r;
        lock_in = l;
        @(posedge clk);
        model_edge({i, r, l});
        #1;
    endtask

    // Asynchronous reset pulse between edges; resumes at a falling edge
    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #2;
        total++;
        if (dut_vec !== '0) begin
            $display("FAIL async_reset: got %b expected %b", dut_vec, {(ST+3){1'b0}});
            bad++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        init_in = 1'b0;
        rstn_in = 1'b0;
        lock_in = 1'b0;
        rst     = 1'b1;
        model_reset();
        #5;
        total++;
        if (dut_vec !== '0) begin
            $display("FAIL reset_no_clock: got %b expected 0", dut_vec);
            bad++;
        end
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_vec !== '0) begin
            $display("FAIL reset_held: got %b expected 0", dut_vec);
            bad++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick(1'b0, 1'b0, 1'b0);
            total++;
            if (dut_vec !== exp_vec || dut_vec !== '0) begin
                $display("FAIL idle_after_reset: cycle %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
        end
    endtask

    task automatic test_nominal();
        for (int n = 1; n <= 32; n++) begin
            tick(1'b1, 1'b1, 1'b1);
            total++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL nominal_model: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
            if (n == 11 || n == 18 || n == 19 || n == 23 || n == 26 || n == 27) begin
                total++;
                if ((n == 11 && led !== 1'b1) ||
                    (n == 18 && (fab !== 3'b000 || led !== 1'b1)) ||
                    (n == 19 && (fab !== 3'b001 || led !== 1'b0)) ||
                    (n == 23 && fab !== 3'b011) ||
                    (n == 26 && (fab !== 3'b011 || rdy !== 1'b0)) ||
                    (n == 27 && (fab !== 3'b111 || rdy !== 1'b1 || led !== 1'b1))) begin
                    $display("FAIL nominal_edge: edge %0d got fab=%b ready=%b led=%b", n, fab, rdy, led);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_fault();
        for (int n = 1; n <= 12; n++) begin
            tick(1'b1, 1'b1, 1'b0);
            total++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL fault_model: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
            if (n == 2 || n == 3 || n == 5 || n == 7) begin
                total++;
                if ((n == 2 && (flt !== 1'b0 || rdy !== 1'b1)) ||
                    (n == 3 && (flt !== 1'b1 || rdy !== 1'b0 || fab !== 3'b000 || led !== 1'b0)) ||
                    (n == 5 && led !== 1'b1) ||
                    (n == 7 && led !== 1'b0)) begin
                    $display("FAIL fault_entry: edge %0d got fault=%b ready=%b fab=%b led=%b", n, flt, rdy, fab, led);
                    bad++;
                end
            end
        end
        for (int n = 1; n <= 10; n++) begin
            tick(1'b1, 1'b1, 1'b1);
            total++;
            if (dut_vec !== exp_vec || flt !== 1'b1) begin
                $display("FAIL fault_sticky: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
        end
        tick(1'b1, 1'b0, 1'b1);
        for (int n = 1; n <= 40; n++) begin
            tick(1'b1, 1'b1, 1'b1);
            total++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL fault_rerun: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
            if (n == 1 || n == 2 || n == 19 || n == 27) begin
                total++;
                if ((n == 1 && flt !== 1'b1) ||
                    (n == 2 && (flt !== 1'b0 || fab !== 3'b000)) ||
                    (n == 19 && fab !== 3'b001) ||
                    (n == 27 && (fab !== 3'b111 || rdy !== 1'b1))) begin
                    $display("FAIL fault_clear: edge %0d got fault=%b fab=%b ready=%b", n, flt, fab, rdy);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_same_cycle_abort();
        for (int n = 1; n <= 4; n++) begin
            tick(1'b1, 1'b0, 1'b0);
            total++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL abort_model: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
            if (n == 2 || n == 3) begin
                total++;
                if ((n == 2 && rdy !== 1'b1) ||
                    (n == 3 && (flt !== 1'b0 || rdy !== 1'b0 || fab !== 3'b000))) begin
                    $display("FAIL abort_priority: edge %0d got fault=%b ready=%b fab=%b", n, flt, rdy, fab);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_lock_glitch();
        pulse_reset();
        for (int n = 1; n <= 10; n++) begin
            tick(1'b1, 1'b1, 1'b1);
            total++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL glitch_pre: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
        end
        for (int n = 1; n <= 3; n++) begin
            tick(1'b1, 1'b1, 1'b0);
            total++;
            if (dut_vec !== exp_vec || fab !== 3'b000) begin
                $display("FAIL glitch_low: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
        end
        for (int n = 1; n <= 20; n++) begin
            tick(1'b1, 1'b1, 1'b1);
            total++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL glitch_model: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
            if (n == 18 || n == 19) begin
                total++;
                if ((n == 18 && fab !== 3'b000) || (n == 19 && fab !== 3'b001)) begin
                    $display("FAIL glitch_release: edge %0d got fab=%b", n, fab);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_release();
        pulse_reset();
        for (int n = 1; n <= 23; n++) begin
            tick(1'b1, 1'b1, 1'b1);
            total++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL midrel_model: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
        end
        total++;
        if (fab !== 3'b011) begin
            $display("FAIL midrel_stage: got fab=%b expected 011", fab);
            bad++;
        end
        pulse_reset();
        for (int n = 1; n <= 19; n++) begin
            tick(1'b1, 1'b1, 1'b1);
            total++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL midrel_restart: edge %0d got %b expected %b", n, dut_vec, exp_vec);
                bad++;
            end
        end
        total++;
        if (fab !== 3'b001) begin
            $display("FAIL midrel_first: got fab=%b expected 001", fab);
            bad++;
        end
    endtask

    task automatic test_random();
        logic [2:0] cur;
        cur = 3'b111;
        for (int n = 1; n <= 3000; n++) begin
            for (int b = 0; b < 3; b++) begin
                if (cur[b]) begin
                    if ($urandom_range(0, 59) == 0) cur[b] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) cur[b] = 1'b1;
                end
            end
            tick(cur[2], cur[1], cur[0]);
            total++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL random_model: cycle %0d in=%b got %b expected %b", n, cur, dut_vec, exp_vec);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_fault();
        test_same_cycle_abort();
        test_lock_glitch();
        test_reset_mid_release();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
